// File: rtl/ex_stage.sv
// Execute stage of the 8-bit RISC-V pipeline.
// Selects forwarded operands, runs the ALU or the iterative multiplier, and
// registers the result with its control bits into the EX/MEM register.
module ex_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_ADDR   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  reg_write_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_to_reg_in,
  input  logic                  mem_write_in,
  input  logic [3:0]            alu_op,
  input  logic                  alu_src,
  input  logic [DATA_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] read_data1,
  input  logic [DATA_WIDTH-1:0] read_data2,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [REG_ADDR-1:0]   rd_in,
  input  logic [1:0]            forward_a,
  input  logic [1:0]            forward_b,
  input  logic [DATA_WIDTH-1:0] ex_mem_result,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  reg_write,
  output logic                  branch,
  output logic                  mem_read,
  output logic                  mem_to_reg,
  output logic                  mem_write,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [REG_ADDR-1:0]   rd_out,
  output logic [DATA_WIDTH-1:0] branch_target,
  output logic                  stall
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  mul_state_t state, state_next;

  logic [DATA_WIDTH-1:0] a_val;
  logic [DATA_WIDTH-1:0] bf_val;
  logic [DATA_WIDTH-1:0] b_val;
  logic [DATA_WIDTH-1:0] alu_comb;
  logic [DATA_WIDTH-1:0] ex_result;

  logic [DATA_WIDTH-1:0] mul_cand;
  logic [DATA_WIDTH-1:0] mul_plier;
  logic [DATA_WIDTH-1:0] mul_acc;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [CNT_W-1:0]      mul_count;

  logic mul_start;
  logic mul_finish;
  logic bubble;

  // Operand A forwarding mux; code 11 falls back to the ID/EX value.
  always_comb begin
    case (forward_a)
      2'b10:   a_val = ex_mem_result;
      2'b01:   a_val = wb_data;
      default: a_val = read_data1;
    endcase
  end

  // Operand B forwarding mux; this value is also the store data.
  always_comb begin
    case (forward_b)
      2'b10:   bf_val = ex_mem_result;
      2'b01:   bf_val = wb_data;
      default: bf_val = read_data2;
    endcase
  end

  assign b_val = alu_src ? imm : bf_val;

  // Single-cycle ALU; MUL is produced by the iterative multiplier instead.
  always_comb begin
    alu_comb = '0;
    case (alu_op)
      OP_AND:  alu_comb = a_val & b_val;
      OP_OR:   alu_comb = a_val | b_val;
      OP_ADD:  alu_comb = a_val + b_val;
      OP_XOR:  alu_comb = a_val ^ b_val;
      OP_SLL:  alu_comb = a_val << b_val[2:0];
      OP_SRL:  alu_comb = a_val >> b_val[2:0];
      OP_SUB:  alu_comb = a_val - b_val;
      OP_SLT:  alu_comb = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_val) < $signed(b_val))};
      default: alu_comb = '0;
    endcase
  end

  // BUSY performs all but the top partial product; DONE folds in the last one.
  assign mul_product = mul_acc + (mul_plier[0] ? mul_cand : '0);
  assign ex_result   = mul_finish ? mul_product : alu_comb;

  // Multiplier next-state, stall and bubble decode; flush overrides every state.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mul_start  = 1'b0;
    mul_finish = 1'b0;
    bubble     = 1'b0;
    if (flush) begin
      state_next = IDLE;
      bubble     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (alu_op == OP_MUL) begin
            mul_start  = 1'b1;
            stall      = 1'b1;
            bubble     = 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (mul_count + 1'b1 == CNT_LAST) begin
            state_next = DONE;
          end
        end
        DONE: begin
          mul_finish = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Multiplier state, operand capture and one shift-add step per BUSY cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mul_count <= '0;
      mul_acc   <= '0;
      mul_cand  <= '0;
      mul_plier <= '0;
    end else begin
      state <= state_next;
      if (mul_start) begin
        mul_cand  <= a_val;
        mul_plier <= b_val;
        mul_acc   <= '0;
        mul_count <= '0;
      end else if (state == BUSY && !flush) begin
        mul_acc   <= mul_acc + (mul_plier[0] ? mul_cand : '0);
        mul_cand  <= mul_cand << 1;
        mul_plier <= mul_plier >> 1;
        mul_count <= mul_count + 1'b1;
      end
    end
  end

  // EX/MEM pipeline register; bubbles clear every control and data field.
  always_ff @(posedge clock) begin
    if (reset || bubble) begin
      reg_write     <= 1'b0;
      branch        <= 1'b0;
      mem_read      <= 1'b0;
      mem_to_reg    <= 1'b0;
      mem_write     <= 1'b0;
      zero          <= 1'b0;
      ALU_result    <= '0;
      write_data    <= '0;
      rd_out        <= '0;
      branch_target <= '0;
    end else begin
      reg_write     <= reg_write_in;
      branch        <= branch_in;
      mem_read      <= mem_read_in;
      mem_to_reg    <= mem_to_reg_in;
      mem_write     <= mem_write_in;
      zero          <= (ex_result == '0);
      ALU_result    <= ex_result;
      write_data    <= bf_val;
      rd_out        <= rd_in;
      branch_target <= pc_in + imm;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized
// instructions compared against an arithmetic reference model.
module tb_ex_stage;

  localparam int DW = 8;
  localparam int RA = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in;
  logic [3:0]    alu_op;
  logic          alu_src;
  logic [DW-1:0] pc_in, read_data1, read_data2, imm;
  logic [RA-1:0] rd_in;
  logic [1:0]    forward_a, forward_b;
  logic [DW-1:0] ex_mem_result, wb_data;
  logic          reg_write, branch, mem_read, mem_to_reg, mem_write, zero;
  logic [DW-1:0] ALU_result, write_data, branch_target;
  logic [RA-1:0] rd_out;
  logic          stall;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ex_stage #(.DATA_WIDTH(DW), .REG_ADDR(RA)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .reg_write_in(reg_write_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_to_reg_in(mem_to_reg_in), .mem_write_in(mem_write_in),
    .alu_op(alu_op), .alu_src(alu_src), .pc_in(pc_in),
    .read_data1(read_data1), .read_data2(read_data2), .imm(imm), .rd_in(rd_in),
    .forward_a(forward_a), .forward_b(forward_b),
    .ex_mem_result(ex_mem_result), .wb_data(wb_data),
    .reg_write(reg_write), .branch(branch), .mem_read(mem_read),
    .mem_to_reg(mem_to_reg), .mem_write(mem_write), .zero(zero),
    .ALU_result(ALU_result), .write_data(write_data), .rd_out(rd_out),
    .branch_target(branch_target), .stall(stall)
  );

  // Reference operand selection: code 10 = EX/MEM, 01 = WB, anything else = register.
  function automatic logic [7:0] ref_operand(input logic [1:0] code, input logic [7:0] reg_val,
                                             input logic [7:0] exm, input logic [7:0] wb);
    if (code == 2'b10) return exm;
    if (code == 2'b01) return wb;
    return reg_val;
  endfunction

  // Reference ALU expressed with integer arithmetic, truncated to 8 bits.
  function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int r, sa, sb, sh;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    sh = int'(b[2:0]);
    case (op)
      4'd0: r = int'(a & b);
      4'd1: r = int'(a | b);
      4'd2: r = int'(a) + int'(b);
      4'd3: r = int'(a ^ b);
      4'd4: r = int'(a) * (2 ** sh);
      4'd5: r = int'(a) / (2 ** sh);
      4'd6: r = int'(a) - int'(b);
      4'd7: r = (sa < sb) ? 1 : 0;
      4'd8: r = int'(a) * int'(b);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic set_nop();
    flush = 1'b0;
    reg_write_in = 1'b0; branch_in = 1'b0; mem_read_in = 1'b0;
    mem_to_reg_in = 1'b0; mem_write_in = 1'b0;
    alu_op = 4'b0000; alu_src = 1'b0;
    pc_in = '0; read_data1 = '0; read_data2 = '0; imm = '0; rd_in = '0;
    forward_a = 2'b00; forward_b = 2'b00; ex_mem_result = '0; wb_data = '0;
  endtask

  // Called at a falling edge right after driving an instruction. Holds the
  // inputs while stall is high (as the hazard unit would) and returns just
  // after the edge on which the instruction was latched into EX/MEM.
  task automatic run_instr(output int stalls, output int bad_bubbles, output logic timed_out);
    logic st;
    logic done;
    stalls = 0;
    bad_bubbles = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1 st = stall;
      @(posedge clock);
      #1;
      if (!st) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (reg_write || branch || mem_read || mem_to_reg || mem_write || ALU_result != 8'h00)
          bad_bubbles++;
        @(negedge clock);
      end
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    set_nop();
    reg_write_in = 1'b1; alu_op = 4'b0010; read_data1 = 8'h05; rd_in = 5'd7; pc_in = 8'h20;
    @(posedge clock);
    @(posedge clock);
    #1;
    checks++;
    if (ALU_result !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_alu got %h expected 00", ALU_result);
    end
    checks++;
    if ({reg_write, branch, mem_read, mem_to_reg, mem_write, zero} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl got %b expected 000000",
                         {reg_write, branch, mem_read, mem_to_reg, mem_write, zero});
    end
    checks++;
    if ({write_data, rd_out, branch_target} !== 21'h0) begin
      errors++; $display("[TB] FAIL reset_data got %h expected 0", {write_data, rd_out, branch_target});
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall);
    end
    @(negedge clock);
    reset = 1'b0;
    set_nop();
  endtask

  task automatic test_forward_add();
    int st, bad;
    logic to;
    @(negedge clock);
    set_nop();
    read_data1 = 8'h05; forward_a = 2'b10; ex_mem_result = 8'h30;
    read_data2 = 8'h07; alu_op = 4'b0010; reg_write_in = 1'b1; rd_in = 5'd9;
    run_instr(st, bad, to);
    checks++;
    if (st != 0 || to) begin
      errors++; $display("[TB] FAIL add_stall got %0d cycles expected 0", st);
    end
    checks++;
    if (ALU_result !== 8'h37 || zero !== 1'b0) begin
      errors++; $display("[TB] FAIL add_result got %h/z%b expected 37/z0", ALU_result, zero);
    end
    checks++;
    if (reg_write !== 1'b1 || rd_out !== 5'd9) begin
      errors++; $display("[TB] FAIL add_ctrl got rw%b rd%0d expected rw1 rd9", reg_write, rd_out);
    end
  endtask

  task automatic test_branch();
    int st, bad;
    logic to;
    @(negedge clock);
    set_nop();
    read_data1 = 8'h42; read_data2 = 8'h42; alu_op = 4'b0110;
    branch_in = 1'b1; pc_in = 8'h10; imm = 8'hF8;
    run_instr(st, bad, to);
    checks++;
    if (ALU_result !== 8'h00 || zero !== 1'b1 || branch !== 1'b1) begin
      errors++; $display("[TB] FAIL beq_compare got %h/z%b/b%b expected 00/z1/b1", ALU_result, zero, branch);
    end
    checks++;
    if (branch_target !== 8'h08) begin
      errors++; $display("[TB] FAIL beq_target got %h expected 08", branch_target);
    end
  endtask

  task automatic test_slt_store();
    int st, bad;
    logic to;
    @(negedge clock);
    set_nop();
    read_data1 = 8'hFE; read_data2 = 8'h01; alu_op = 4'b0111; reg_write_in = 1'b1;
    run_instr(st, bad, to);
    checks++;
    if (ALU_result !== 8'h01) begin
      errors++; $display("[TB] FAIL slt_signed got %h expected 01", ALU_result);
    end
    @(negedge clock);
    set_nop();
    read_data1 = 8'h20; read_data2 = 8'h99; alu_src = 1'b1; imm = 8'h04;
    alu_op = 4'b0010; mem_write_in = 1'b1;
    run_instr(st, bad, to);
    checks++;
    if (ALU_result !== 8'h24 || write_data !== 8'h99 || mem_write !== 1'b1) begin
      errors++; $display("[TB] FAIL store_path got addr %h data %h mw%b expected 24 99 1",
                         ALU_result, write_data, mem_write);
    end
  endtask

  task automatic test_multiply();
    int st, bad;
    logic to;
    @(negedge clock);
    set_nop();
    read_data1 = 8'd13; read_data2 = 8'd11; alu_op = 4'b1000; reg_write_in = 1'b1; rd_in = 5'd3;
    run_instr(st, bad, to);
    checks++;
    if (st != 8 || bad != 0 || to) begin
      errors++; $display("[TB] FAIL mul_timing got %0d stalls %0d bad bubbles expected 8 0", st, bad);
    end
    checks++;
    if (ALU_result !== 8'h8F || reg_write !== 1'b1 || rd_out !== 5'd3) begin
      errors++; $display("[TB] FAIL mul_13x11 got %h rw%b expected 8f rw1", ALU_result, reg_write);
    end
    // Back-to-back multiply; operand A is forwarded and then disturbed mid-run.
    @(negedge clock);
    set_nop();
    forward_a = 2'b10; ex_mem_result = 8'd20; read_data2 = 8'd20;
    alu_op = 4'b1000; reg_write_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("[TB] FAIL mul2_start_stall got %b expected 1", stall);
    end
    @(negedge clock);
    ex_mem_result = 8'h55;
    run_instr(st, bad, to);
    checks++;
    if (st != 7 || bad != 0 || to) begin
      errors++; $display("[TB] FAIL mul2_timing got %0d remaining stalls expected 7", st);
    end
    checks++;
    if (ALU_result !== 8'h90 || write_data !== 8'd20) begin
      errors++; $display("[TB] FAIL mul_20x20 got %h wd %h expected 90 14", ALU_result, write_data);
    end
  endtask

  task automatic test_flush();
    int st, bad;
    logic to;
    // Flush in the cycle a multiply would start.
    @(negedge clock);
    set_nop();
    read_data1 = 8'd2; read_data2 = 8'd3; alu_op = 4'b1000; reg_write_in = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_start_stall got %b expected 0", stall);
    end
    @(posedge clock);
    #1;
    checks++;
    if (reg_write !== 1'b0 || ALU_result !== 8'h00) begin
      errors++; $display("[TB] FAIL flush_start_bubble got rw%b %h expected rw0 00", reg_write, ALU_result);
    end
    @(negedge clock);
    flush = 1'b0;
    run_instr(st, bad, to);
    checks++;
    if (st != 8 || ALU_result !== 8'h06 || to) begin
      errors++; $display("[TB] FAIL mul_after_flush got %0d stalls result %h expected 8 06", st, ALU_result);
    end
    // Flush in the fourth stall cycle of a multiply.
    @(negedge clock);
    set_nop();
    read_data1 = 8'd13; read_data2 = 8'd11; alu_op = 4'b1000; reg_write_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_mid_stall got %b expected 0", stall);
    end
    @(posedge clock);
    #1;
    checks++;
    if ({reg_write, branch, mem_read, mem_to_reg, mem_write} !== 5'b0 || ALU_result !== 8'h00) begin
      errors++; $display("[TB] FAIL flush_mid_bubble got ctrl %b %h expected 00000 00",
                         {reg_write, branch, mem_read, mem_to_reg, mem_write}, ALU_result);
    end
    @(negedge clock);
    set_nop();
    read_data1 = 8'd1; read_data2 = 8'd2; alu_op = 4'b0010; reg_write_in = 1'b1;
    run_instr(st, bad, to);
    checks++;
    if (st != 0 || ALU_result !== 8'h03 || to) begin
      errors++; $display("[TB] FAIL add_after_flush got %0d stalls result %h expected 0 03", st, ALU_result);
    end
  endtask

  task automatic test_reset_mul();
    int st, bad;
    logic to;
    @(negedge clock);
    set_nop();
    read_data1 = 8'd13; read_data2 = 8'd11; alu_op = 4'b1000; reg_write_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    set_nop();
    @(posedge clock);
    #1;
    checks++;
    if ({reg_write, branch, mem_read, mem_to_reg, mem_write, zero} !== 6'b0 || ALU_result !== 8'h00 ||
        stall !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_mul got ctrl %b %h stall %b expected 0 00 0",
                         {reg_write, branch, mem_read, mem_to_reg, mem_write, zero}, ALU_result, stall);
    end
    @(negedge clock);
    reset = 1'b0;
    read_data1 = 8'd3; read_data2 = 8'd3; alu_op = 4'b1000; reg_write_in = 1'b1;
    run_instr(st, bad, to);
    checks++;
    if (st != 8 || ALU_result !== 8'h09 || reg_write !== 1'b1 || to) begin
      errors++; $display("[TB] FAIL mul_after_reset got %0d stalls result %h expected 8 09", st, ALU_result);
    end
  endtask

  task automatic test_random();
    int st, bad, exp_st;
    logic to;
    logic [7:0] a, bf, b, exp_res;
    logic [4:0] exp_ctrl;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      set_nop();
      alu_op = 4'($urandom_range(0, 10));
      alu_src = 1'($urandom);
      read_data1 = 8'($urandom); read_data2 = 8'($urandom); imm = 8'($urandom);
      pc_in = 8'($urandom); rd_in = 5'($urandom);
      forward_a = 2'($urandom); forward_b = 2'($urandom);
      ex_mem_result = 8'($urandom); wb_data = 8'($urandom);
      {reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in} = 5'($urandom);
      a = ref_operand(forward_a, read_data1, ex_mem_result, wb_data);
      bf = ref_operand(forward_b, read_data2, ex_mem_result, wb_data);
      b = alu_src ? imm : bf;
      exp_res = ref_alu(alu_op, a, b);
      exp_st = (alu_op == 4'b1000) ? 8 : 0;
      exp_ctrl = {reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in};
      run_instr(st, bad, to);
      checks++;
      if (st != exp_st || bad != 0 || to) begin
        errors++; $display("[TB] FAIL rand%0d_stall op %h got %0d stalls %0d bad expected %0d",
                           n, alu_op, st, bad, exp_st);
      end
      checks++;
      if (ALU_result !== exp_res || zero !== (exp_res == 8'h00)) begin
        errors++; $display("[TB] FAIL rand%0d_result op %h got %h z%b expected %h", n, alu_op,
                           ALU_result, zero, exp_res);
      end
      checks++;
      if ({reg_write, branch, mem_read, mem_to_reg, mem_write} !== exp_ctrl) begin
        errors++; $display("[TB] FAIL rand%0d_ctrl got %b expected %b", n,
                           {reg_write, branch, mem_read, mem_to_reg, mem_write}, exp_ctrl);
      end
      checks++;
      if (write_data !== bf || rd_out !== rd_in || branch_target !== 8'(int'(pc_in) + int'(imm))) begin
        errors++; $display("[TB] FAIL rand%0d_data got wd %h rd %0d bt %h expected %h %0d %h", n,
                           write_data, rd_out, branch_target, bf, rd_in, 8'(int'(pc_in) + int'(imm)));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    set_nop();
    test_reset();
    test_forward_add();
    test_branch();
    test_slt_store();
    test_multiply();
    test_flush();
    test_reset_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the summary line");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit RISC-V pipeline, between the ID/EX register and the memory stage.
- Performs operand forwarding, ALU operations and a multi-cycle iterative multiply, and computes the branch target.
- Registers all results and control into the EX/MEM pipeline register consumed by the memory stage.
- Asserts stall to the hazard unit while a multiply is in progress.

Parameters:
- DATA_WIDTH, 8, datapath and PC width; multiply iteration count.
- REG_ADDR, 5, register-file index width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  branch taken in memory stage; kill the current EX instruction
- reg_write_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in  in  1 each  ID/EX control bits
- alu_op  in  4  operation select
- alu_src  in  1  1 = operand B is imm
- pc_in  in  DATA_WIDTH  instruction PC
- read_data1, read_data2  in  DATA_WIDTH  ID/EX register operands
- imm  in  DATA_WIDTH  sign-extended immediate (byte offset for branches)
- rd_in  in  REG_ADDR  destination register
- forward_a, forward_b  in  2  00 = ID/EX value, 10 = EX/MEM result, 01 = WB data
- ex_mem_result  in  DATA_WIDTH  forwarded EX/MEM ALU result
- wb_data  in  DATA_WIDTH  forwarded writeback data
- reg_write, branch, mem_read, mem_to_reg, mem_write  out  1 each  registered control to memory stage
- zero  out  1  registered (ALU_result == 0)
- ALU_result  out  DATA_WIDTH  registered result / memory address
- write_data  out  DATA_WIDTH  registered forwarded operand B (pre-imm mux), store data
- rd_out  out  REG_ADDR  registered destination
- branch_target  out  DATA_WIDTH  registered pc_in + imm, mod 2^DATA_WIDTH
- stall  out  1  combinational; hazard unit holds PC, IF/ID and ID/EX while high

Behaviour:
- Reset: all registered outputs 0; multiplier state IDLE; counter 0. Reset takes priority over flush and over any in-flight multiply.
- Operand selection:
  - A = forward_a mux.
  - Bf = forward_b mux.
  - B = alu_src ? imm : Bf.
  - Forward code 11 behaves as 00.
- alu_op encoding (results truncated to DATA_WIDTH):
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL by B[2:0]
  - 0101 SRL by B[2:0]
  - 0110 SUB
  - 0111 SLT (signed, result 1/0)
  - 1000 MUL (low DATA_WIDTH bits of unsigned product)
  - other codes give result 0
- Single-cycle operations: EX/MEM outputs update on the next clock edge; latency 1; stall = 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE, alu_op = MUL, no flush:
    - Capture A and B.
    - Clear accumulator; counter = 0.
    - Go to BUSY.
    - stall = 1.
    - EX/MEM latches a bubble: all control outputs 0, data outputs 0.
  - BUSY:
    - One shift-add step per cycle; counter increments.
    - stall = 1; bubble into EX/MEM.
    - When counter reaches DATA_WIDTH-1, go to DONE.
  - DONE:
    - stall = 0.
    - EX/MEM latches the product with the held ID/EX control, rd_in and forwarded Bf.
    - Go to IDLE.
  - stall is high for exactly DATA_WIDTH cycles per multiply. The result reaches the EX/MEM outputs DATA_WIDTH+1 edges after the multiply is first presented.
  - Operands are captured at start only. Forwarding-source changes while BUSY are ignored.
  - A multiply immediately following a multiply (held or newly presented in the DONE cycle) starts a new multiply on the next IDLE.
- flush:
  - EX/MEM latches a bubble that cycle.
  - FSM returns to IDLE.
  - stall = 0 in that cycle (stall = busy & ~flush).
  - This applies in any state, including the cycle a multiply would start.
- branch_target and zero are registered alongside ALU_result.
- The memory stage forms PCScr = branch & zero from these registered outputs.

Test Plan:
- Forwarded ADD: read_data1 = 5, forward_a = 10, ex_mem_result = 0x30, read_data2 = 7, alu_op = 0010, reg_write_in = 1 -> next edge ALU_result = 0x37, zero = 0, reg_write = 1, stall never high.
- BEQ compare: A = B = 0x42, alu_op = 0110, branch_in = 1, pc_in = 0x10, imm = 0xF8 -> next edge ALU_result = 0, zero = 1, branch = 1, branch_target = 0x08.
- SLT signed and store path: A = 0xFE, B = 0x01, alu_op = 0111 -> ALU_result = 1. A = 0x20, read_data2 = 0x99, alu_src = 1, imm = 4, mem_write_in = 1 -> ALU_result = 0x24, write_data = 0x99.
- Multiply timing: A = 13, B = 11, alu_op = 1000, reg_write_in = 1, inputs held while stall is high -> stall high exactly 8 cycles with reg_write = 0 bubbles; on edge 9 ALU_result = 143 (0x8F), reg_write = 1. Repeat with 20 × 20 -> ALU_result = 0x90.
- Flush mid-multiply: start 13 × 11, assert flush in the 4th stall cycle -> stall low that cycle, next edge all controls 0, FSM IDLE. A following ADD of 1 + 2 completes in 1 cycle with result 3.
- Reset mid-multiply: start a multiply, assert reset in the 3rd stall cycle -> next edge all outputs 0, stall 0. After release a new 3 × 3 multiply yields 9 after 8 stall cycles.
